paddle_array_ctrl: RTL and testbench
====================================

Name: paddle_array_ctrl

Overview:
- Parametrised multi-player paddle controller for the Pong datapath; replaces per-player single-paddle movers with one block driving NUM_PADDLES paddles.
- Each channel steps its paddle on a button press edge, auto-repeats while the button is held, and clamps exactly to the configured bounds.
- Sits between the debounced button inputs and the renderer and collision logic; advances only on enable ticks (frame tick or game-run gate).

Parameters:
- NUM_PADDLES, 2, number of independent paddle channels (1..8).
- X_WIDTH, 10, width of each X position field.
- Y_WIDTH, 9, width of each Y position field.
- X_BASE, 120, X position of paddle 0.
- X_SPACING, 400, X offset between consecutive paddles: x[i] = X_BASE + i*X_SPACING.
- Y_START, 240, Y position after reset.
- TOP, 185, minimum Y.
- BOTTOM, 305, maximum Y.
- STEP, 15, Y change per move.
- REPEAT_DELAY, 8, held enable ticks after the initial step before the first repeat step; 0 disables auto-repeat.
- REPEAT_PERIOD, 4, enable ticks between repeat steps (must be >= 1).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- enable, input, 1, update qualifier; when low all state is frozen.
- button, input, 2*NUM_PADDLES, active-low buttons; bit 2i = down for channel i, bit 2i+1 = up for channel i.
- x_pos, output, X_WIDTH*NUM_PADDLES, packed X positions; channel i occupies [i*X_WIDTH +: X_WIDTH].
- y_pos, output, Y_WIDTH*NUM_PADDLES, packed Y positions, same packing.
- at_top, output, NUM_PADDLES, bit i = 1 when y[i] == TOP.
- at_bottom, output, NUM_PADDLES, bit i = 1 when y[i] == BOTTOM.
- moved, output, NUM_PADDLES, one-cycle pulse when y[i] changed at the last edge.

Behaviour:
- Reset values: y[i] = Y_START; x[i] = X_BASE + i*X_SPACING (constant afterwards); button_prev = all ones; state IDLE; repeat counters = 0; moved = 0.
- at_top and at_bottom are combinational from y.
- All per-channel logic is independent and replicated by generate. The channel logic below applies only on cycles with enable = 1.
- enable = 0: y, state, counters and button_prev hold; moved = 0.
- Per-channel decode:
  - dn = ~button[2i], up = ~button[2i+1].
  - Both asserted, or neither asserted: treat as no request; state goes to IDLE; no move.
- IDLE:
  - Down falling edge (dn = 1, prev down bit = 1, up = 0): y <= min(y+STEP, BOTTOM); state goes to HOLD_DN; cnt <= REPEAT_DELAY.
  - Up falling edge (mirror): y <= max(y-STEP, TOP); state goes to HOLD_UP; cnt <= REPEAT_DELAY.
  - A change to y takes effect at the same edge and is visible the next cycle; moved[i] pulses that same cycle only if y actually changed.
- HOLD_DN and HOLD_UP:
  - Matching button still held alone:
    - REPEAT_DELAY = 0: no repeat; stay in state.
    - Else if cnt > 1: cnt decrements.
    - Else (cnt <= 1): step with clamp; cnt <= REPEAT_PERIOD.
  - Button released, opposite button pressed, or both pressed: go to IDLE with no move.
  - A new press edge after that is handled from IDLE on the following enable tick.
- Clamp arithmetic: compute in Y_WIDTH+1 bits to avoid wrap.
  - y+STEP > BOTTOM gives BOTTOM.
  - y < TOP+STEP gives TOP.
  - At a bound, a press produces no change and moved = 0, but the state machine still enters HOLD.
- button_prev[i] <= button[i] on every enable cycle.
- Reset asserted mid-hold: immediate return to reset values; button_prev = ones, so a button held through reset release counts as a new edge on the first enable tick.

Test Plan:
- Reset, enable = 1, press down on ch0 for 1 cycle then release -> y0 goes 240 to 255 one cycle later; moved[0] pulses once; ch1 stays at 240.
- Hold up on ch1 for 20 enable ticks with REPEAT_DELAY = 8, REPEAT_PERIOD = 4 -> steps at tick 0 (225), tick 8 (210), tick 12 (195), tick 16 (185 clamped); at_top[1] = 1; no further moved pulses.
- y0 = 300, press down -> y0 = 305 (clamped, not 315); press again -> y0 stays 305; moved stays 0; at_bottom[0] = 1.
- Both buttons on ch0 pressed in the same cycle -> no move; state IDLE; then releasing up while down is held produces no step (no new down edge).
- Hold down with enable toggling 1/0 -> counter advances only on enable = 1 cycles; repeat timing is measured in enable ticks; moved = 0 while enable = 0.
- Assert reset while ch0 is in HOLD_DN with y0 = 270, keep down held through reset release -> y0 = 240 on reset, then 255 on the first enable tick.

Source files
------------

// File: rtl/paddle_array_ctrl.sv
// Multi-channel paddle controller: each channel steps its paddle's Y position on a
// button press edge, auto-repeats while the button stays held, and clamps to [TOP, BOTTOM].
module paddle_array_ctrl #(
  parameter int NUM_PADDLES   = 2,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 9,
  parameter int X_BASE        = 120,
  parameter int X_SPACING     = 400,
  parameter int Y_START       = 240,
  parameter int TOP           = 185,
  parameter int BOTTOM        = 305,
  parameter int STEP          = 15,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2*NUM_PADDLES-1:0]       button,
  output logic [X_WIDTH*NUM_PADDLES-1:0] x_pos,
  output logic [Y_WIDTH*NUM_PADDLES-1:0] y_pos,
  output logic [NUM_PADDLES-1:0]         at_top,
  output logic [NUM_PADDLES-1:0]         at_bottom,
  output logic [NUM_PADDLES-1:0]         moved
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]   CNT_PERIOD = CNT_W'(REPEAT_PERIOD);

  // Clamp arithmetic is done one bit wider than Y so y+STEP can never wrap.
  localparam logic [Y_WIDTH:0]   STEP_W     = (Y_WIDTH+1)'(STEP);
  localparam logic [Y_WIDTH:0]   TOP_W      = (Y_WIDTH+1)'(TOP);
  localparam logic [Y_WIDTH:0]   BOTTOM_W   = (Y_WIDTH+1)'(BOTTOM);
  localparam logic [Y_WIDTH-1:0] TOP_Y      = Y_WIDTH'(TOP);
  localparam logic [Y_WIDTH-1:0] BOTTOM_Y   = Y_WIDTH'(BOTTOM);
  localparam logic [Y_WIDTH-1:0] START_Y    = Y_WIDTH'(Y_START);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_DN = 2'd1,
    HOLD_UP = 2'd2
  } state_t;

  logic [2*NUM_PADDLES-1:0] button_prev;

  // Released buttons read high, so resetting to ones makes a button held through
  // reset release look like a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      button_prev <= '1;
    end else if (enable) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      button_prev <= button;
    end
  end

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    state_t             state, state_nxt;
    logic [Y_WIDTH-1:0] y, y_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               moved_q;

    logic               dn, up, dn_edge, up_edge;
    logic [Y_WIDTH:0]   y_ext, y_plus, y_minus;
    logic [Y_WIDTH-1:0] y_step_dn, y_step_up;

    assign dn      = ~button[2*i];
    assign up      = ~button[2*i+1];
    assign dn_edge = dn & ~up & button_prev[2*i];
    assign up_edge = up & ~dn & button_prev[2*i+1];

    assign y_ext     = {1'b0, y};
    assign y_plus    = y_ext + STEP_W;
    assign y_minus   = y_ext - STEP_W;
    assign y_step_dn = (y_plus > BOTTOM_W)        ? BOTTOM_Y : y_plus[Y_WIDTH-1:0];
    assign y_step_up = (y_ext < (TOP_W + STEP_W)) ? TOP_Y    : y_minus[Y_WIDTH-1:0];

    always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      state_nxt = state;
      y_nxt     = y;
      cnt_nxt   = cnt;
      if (enable) begin
        case (state)
          IDLE: begin
            if (dn_edge) begin
              y_nxt     = y_step_dn;
              state_nxt = HOLD_DN;
              cnt_nxt   = CNT_DELAY;
            end else if (up_edge) begin
              y_nxt     = y_step_up;
              state_nxt = HOLD_UP;
              cnt_nxt   = CNT_DELAY;
            end
          end
          HOLD_DN: begin
            if (dn && !up) begin
              if (REPEAT_DELAY != 0) begin
                if (cnt > CNT_ONE) begin
                  cnt_nxt = cnt - CNT_ONE;
                end else begin
                  y_nxt   = y_step_dn;
                  cnt_nxt = CNT_PERIOD;
                end
              end
            end else begin
              state_nxt = IDLE;
            end
          end
          HOLD_UP: begin
            if (up && !dn) begin
              if (REPEAT_DELAY != 0) begin
                if (cnt > CNT_ONE) begin
                  cnt_nxt = cnt - CNT_ONE;
                end else begin
                  y_nxt   = y_step_up;
                  cnt_nxt = CNT_PERIOD;
                end
              end
            end else begin
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        y       <= START_Y;
        cnt     <= '0;
        moved_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        y       <= y_nxt;
        cnt     <= cnt_nxt;
        moved_q <= enable && (y_nxt != y);
      end
    end

    assign x_pos[i*X_WIDTH +: X_WIDTH] = X_WIDTH'(X_BASE + i*X_SPACING);
    assign y_pos[i*Y_WIDTH +: Y_WIDTH] = y;
    assign at_top[i]                   = (y == TOP_Y);
    assign at_bottom[i]                = (y == BOTTOM_Y);
    assign moved[i]                    = moved_q;
  end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Directed plus randomized bench for paddle_array_ctrl; a press-time based model
// (ticks held since the press) predicts every channel's Y, moved and bound flags.
module tb_paddle_array_ctrl;

  localparam int NP     = 2;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int XB     = 120;
  localparam int XS     = 400;
  localparam int YS     = 240;
  localparam int TOP    = 185;
  localparam int BOTTOM = 305;
  localparam int STEP   = 15;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [2*NP-1:0]   button;
  logic [XW*NP-1:0]  x_pos;
  logic [YW*NP-1:0]  y_pos;
  logic [NP-1:0]     at_top, at_bottom, moved;

  int checks = 0;
  int errors = 0;

  // Reference model: hold direction (0 none, 1 down, 2 up) and ticks since the press.
  int              m_y    [NP];
  int              m_hold [NP];
  int              m_t    [NP];
  logic [2*NP-1:0] m_prev;
  logic [NP-1:0]   m_moved;

  paddle_array_ctrl #(
    .NUM_PADDLES(NP), .X_WIDTH(XW), .Y_WIDTH(YW), .X_BASE(XB), .X_SPACING(XS),
    .Y_START(YS), .TOP(TOP), .BOTTOM(BOTTOM), .STEP(STEP),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .x_pos(x_pos), .y_pos(y_pos), .at_top(at_top), .at_bottom(at_bottom), .moved(moved)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int move(input int y, input int dir);
    if (dir == 1) return (y + STEP > BOTTOM) ? BOTTOM : y + STEP;
    return (y - STEP < TOP) ? TOP : y - STEP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_y[i] = YS; m_hold[i] = 0; m_t[i] = 0;
    end
    m_prev  = '1;
    m_moved = '0;
  endtask

  task automatic model_step(input logic en, input logic [2*NP-1:0] btn);
    int  old, dir;
    bit  dn, up, pressed_edge;
    if (!en) begin
      m_moved = '0;
      return;
    end
    for (int i = 0; i < NP; i++) begin
      dn  = !btn[2*i];
      up  = !btn[2*i+1];
      old = m_y[i];
      if (dn == up) begin
        m_hold[i] = 0;
      end else begin
        dir          = dn ? 1 : 2;
        pressed_edge = dn ? m_prev[2*i] : m_prev[2*i+1];
        if (m_hold[i] == dir) begin
          m_t[i]++;
          if (DELAY > 0 && m_t[i] >= DELAY && (m_t[i] - DELAY) % PERIOD == 0)
            m_y[i] = move(old, dir);
        end else if (m_hold[i] == 0) begin
          if (pressed_edge) begin
            m_hold[i] = dir;
            m_t[i]    = 0;
            m_y[i]    = move(old, dir);
          end
        end else begin
          m_hold[i] = 0;
        end
      end
      m_moved[i] = (m_y[i] != old);
    end
    m_prev = btn;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NP; i++) begin
      check($sformatf("x[%0d]", i), 32'(x_pos[i*XW +: XW]), 32'(XB + i*XS));
      check($sformatf("y[%0d]", i), 32'(y_pos[i*YW +: YW]), 32'(m_y[i]));
      check($sformatf("moved[%0d]", i), 32'(moved[i]), 32'(m_moved[i]));
      check($sformatf("at_top[%0d]", i), 32'(at_top[i]), 32'(m_y[i] == TOP));
      check($sformatf("at_bottom[%0d]", i), 32'(at_bottom[i]), 32'(m_y[i] == BOTTOM));
    end
  endtask

  // Apply inputs, advance one edge in DUT and model, then compare just after the edge.
  task automatic tick(input logic en, input logic [2*NP-1:0] btn);
    enable = en;
    button = btn;
    @(posedge clock);
    model_step(en, btn);
    #1;
    compare_all();
  endtask

  // Button vector with the requested channel's down/up pressed (active low).
  function automatic logic [2*NP-1:0] press(input int ch, input bit dn, input bit up);
    logic [2*NP-1:0] b;
    b = '1;
    b[2*ch]   = ~dn;
    b[2*ch+1] = ~up;
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [2*NP-1:0] all_off;
  logic [2*NP-1:0] rnd_btn;
  int              pulses;

  initial begin
    all_off = '1;
    enable  = 1'b0;
    button  = all_off;
    do_reset();

    // Single press on ch0: one step, one moved pulse, ch1 untouched.
    pulses = 0;
    tick(1'b1, press(0, 1, 0)); pulses += int'(moved[0]);
    tick(1'b1, all_off);        pulses += int'(moved[0]);
    tick(1'b1, all_off);        pulses += int'(moved[0]);
    check("single_press_y0", 32'(y_pos[0 +: YW]), 32'd255);
    check("single_press_pulses", 32'(pulses), 32'd1);
    check("single_press_y1", 32'(y_pos[YW +: YW]), 32'd240);

    // Hold up on ch1 for 20 ticks: steps at ticks 0, 8, 12, 16 (last one clamped).
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1'b1, press(1, 0, 1));
      pulses += int'(moved[1]);
      if (t == 8)  check("repeat_first_y1", 32'(y_pos[YW +: YW]), 32'd210);
    end
    tick(1'b1, all_off);
    check("hold_up_y1", 32'(y_pos[YW +: YW]), 32'(TOP));
    check("hold_up_at_top", 32'(at_top[1]), 32'd1);
    check("hold_up_pulses", 32'(pulses), 32'd4);

    // Walk ch0 to 300, then two presses at the bottom bound.
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, press(0, 1, 0));
      tick(1'b1, all_off);
    end
    check("walk_y0", 32'(y_pos[0 +: YW]), 32'd300);
    tick(1'b1, press(0, 1, 0));
    check("clamp_bottom_y0", 32'(y_pos[0 +: YW]), 32'(BOTTOM));
    tick(1'b1, all_off);
    tick(1'b1, press(0, 1, 0));
    check("at_bottom_press_moved", 32'(moved[0]), 32'd0);
    check("at_bottom_flag", 32'(at_bottom[0]), 32'd1);
    tick(1'b1, all_off);

    // Both buttons together, then release up with down held: never a step.
    tick(1'b1, press(0, 0, 1));
    tick(1'b1, all_off);
    tick(1'b1, press(0, 1, 1));
    tick(1'b1, press(0, 1, 1));
    for (int k = 0; k < 12; k++) tick(1'b1, press(0, 1, 0));
    check("both_then_down_y0", 32'(y_pos[0 +: YW]), 32'd290);
    tick(1'b1, all_off);

    // Hold down on ch1 with enable alternating: repeats are counted in enable ticks.
    for (int c = 0; c < 40; c++) tick(c % 2 == 0, press(1, 1, 0));
    check("gated_hold_y1", 32'(y_pos[YW +: YW]), 32'd245);
    tick(1'b1, all_off);

    // Reset mid-hold with y0 = 270 and down held through reset release.
    do_reset();
    tick(1'b1, press(0, 1, 0));
    tick(1'b1, all_off);
    tick(1'b1, press(0, 1, 0));
    tick(1'b1, press(0, 1, 0));
    check("pre_reset_y0", 32'(y_pos[0 +: YW]), 32'd270);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("in_reset_y0", 32'(y_pos[0 +: YW]), 32'(YS));
    compare_all();
    @(negedge clock);
    reset = 1'b0;
    tick(1'b1, press(0, 1, 0));
    check("post_reset_y0", 32'(y_pos[0 +: YW]), 32'd255);
    tick(1'b1, all_off);

    // Randomized traffic: buttons change occasionally so holds and repeats occur.
    rnd_btn = all_off;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 7) == 0) rnd_btn[2*i +: 2] = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, rnd_btn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
